// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register file write scheduler.
package regfile_write_scheduler_pkg;

  localparam int unsigned NUM_WB_PORTS_DEFAULT = 2;
  localparam int unsigned NUM_ARCH_REGS        = 32;
  localparam int unsigned XLEN                 = 32;
  localparam int unsigned RS_ADDR_W            = 5;
  // One extra bit so the sweep can tell "issued x31" from "not started"
  localparam int unsigned CLR_CNT_W            = 6;

  typedef logic [RS_ADDR_W-1:0] rs_addr_t;
  typedef logic [XLEN-1:0]      rf_data_t;

  typedef enum logic {
    INIT_CLEAR = 1'b0,
    RUN        = 1'b1
  } wb_sched_state_t;

  // One write presented to the register file port
  typedef struct packed {
    logic     commit;
    rs_addr_t rd_addr;
    rf_data_t data;
  } rf_write_t;

  // Index width that stays legal for a single requester
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_wb_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer wins.
module wb_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant_c,
  output logic [IDX_W-1:0]     index_c,
  output logic                 any_c
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan requesters starting at ptr, wrapping modulo NUM_PORTS
  always_comb begin
    grant_c  = '0;
    index_c  = '0;
    any_c    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      cand_idx = IDX_W'(cand);
      if (!any_c && req[cand_idx]) begin
        any_c             = 1'b1;
        grant_c[cand_idx] = 1'b1;
        index_c           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Clears all 32 registers after reset, then shares the register file write
// port round-robin among the writeback requesters, one registered commit per cycle.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int unsigned NUM_WB_PORTS = NUM_WB_PORTS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WB_PORTS-1:0]      wb_valid,
  input  logic [NUM_WB_PORTS-1:0][4:0] wb_rd_addr,
  input  logic [NUM_WB_PORTS-1:0][31:0] wb_data,
  output logic [NUM_WB_PORTS-1:0]      wb_ack,
  output logic [4:0]                   rf_rd_addr,
  output logic [31:0]                  rf_new_data,
  output logic                         rf_commit,
  output logic                         init_done
);

  localparam int unsigned IDX_W = idx_width(NUM_WB_PORTS);

  wb_sched_state_t        state, state_next;
  logic [CLR_CNT_W-1:0]   clr_cnt, clr_cnt_next;
  logic [IDX_W-1:0]       ptr, ptr_next;
  rf_write_t              rf_q, rf_next;
  logic                   init_done_next;

  logic [NUM_WB_PORTS-1:0] gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_any;
  rs_addr_t                gnt_addr;
  rf_data_t                gnt_data;

  wb_rr_arbiter #(
    .NUM_PORTS (NUM_WB_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req     (wb_valid),
    .ptr     (ptr),
    .grant_c (gnt),
    .index_c (gnt_idx),
    .any_c   (gnt_any)
  );

  assign gnt_addr = wb_rd_addr[gnt_idx];
  assign gnt_data = wb_data[gnt_idx];

  // State, sweep counter, pointer and register-file outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT_CLEAR;
      clr_cnt   <= '0;
      ptr       <= '0;
      rf_q      <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      ptr       <= ptr_next;
      rf_q      <= rf_next;
      init_done <= init_done_next;
    end
  end

  // Next-state, next-output and combinational grant
  always_comb begin
    state_next     = state;
    clr_cnt_next   = clr_cnt;
    ptr_next       = ptr;
    rf_next        = rf_q;
    rf_next.commit = 1'b0;
    wb_ack         = '0;

    unique case (state)
      INIT_CLEAR: begin
        if (clr_cnt < CLR_CNT_W'(NUM_ARCH_REGS)) begin
          rf_next.commit  = 1'b1;
          rf_next.rd_addr = clr_cnt[RS_ADDR_W-1:0];
          rf_next.data    = '0;
          clr_cnt_next    = clr_cnt + CLR_CNT_W'(1);
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (gnt_any) begin
          wb_ack = gnt;
          if (gnt_idx == IDX_W'(NUM_WB_PORTS - 1)) begin
            ptr_next = '0;
          end else begin
            ptr_next = gnt_idx + IDX_W'(1);
          end
          // x0 writes are consumed but never reach the file
          if (gnt_addr != '0) begin
            rf_next.commit  = 1'b1;
            rf_next.rd_addr = gnt_addr;
            rf_next.data    = gnt_data;
          end
        end
      end
      default: state_next = INIT_CLEAR;
    endcase

    init_done_next = (state_next == RUN);
  end

  assign rf_commit   = rf_q.commit;
  assign rf_rd_addr  = rf_q.rd_addr;
  assign rf_new_data = rf_q.data;

endmodule
